seq_div_go_done: RTL and testbench
==================================

# seq_div_go_done

Multi-cycle unsigned restoring divider that implements the responder side of the go/done handshake used by every generated `main` component and its primitives. A parent controller asserts `go`, and the block latches its operands, computes one quotient bit per cycle, and pulses `done` with results valid. It is the reusable leaf that simulation harnesses exercise indirectly through `main`. It also serves as the template for future go/done multi-cycle primitives.

## Interface
- `WIDTH`, default 32: operand and result width in bits; legal values ≥ 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserting it (low) clears all state immediately. Release is sampled on `clk`.
- `go`  in  1  start request; sampled only in IDLE.
- `left`  in  WIDTH  dividend; captured when `go` is accepted.
- `right`  in  WIDTH  divisor; captured when `go` is accepted.
- `out_quotient`  out  WIDTH  quotient; registered.
- `out_remainder`  out  WIDTH  remainder; registered.
- `done`  out  1  one-cycle completion pulse; registered.

## Operation
- States:
  - IDLE: waits for a start request.
  - BUSY: computes one quotient bit per cycle.
  - DONE: presents the completion pulse.
- IDLE with `go`=1 at an edge:
  - latch `left` into the dividend shift register and `right` into the divisor register;
  - clear the (WIDTH+1)-bit partial remainder;
  - clear the step counter;
  - go to BUSY.
- BUSY, each cycle:
  - form `{rem, dvd} << 1`;
  - trial value = shifted remainder − divisor, computed WIDTH+1 bits wide;
  - if trial ≥ 0, keep it and shift in quotient bit 1; otherwise restore and shift in 0;
  - increment the counter.
- After step WIDTH−1: load the final quotient and remainder (low WIDTH bits) into the output registers, then go to DONE.
- DONE: `done`=1 for exactly one cycle, then unconditionally return to IDLE.
- Changes to `left`/`right` after capture are ignored.
- Deasserting `go` in BUSY does not abort; the operation completes.
- `go` still high when the block returns to IDLE starts a new operation. A parent that holds `go` through `done` therefore gets back-to-back runs.
- `out_quotient`/`out_remainder` hold their last values until the next completion. Only the results of a new completion change them.
- Divide by zero (natural result): quotient = all ones, remainder = `left`.

## Timing
- Reset values: `done`=0, `out_quotient`=0, `out_remainder`=0; state IDLE; counter 0.
- Reset mid-operation aborts at once. No `done` is issued. Outputs go to 0.
- Latency: `go` is sampled high at edge 0. BUSY lasts edges 1..WIDTH. `done` is high in the cycle after edge WIDTH+1, i.e. WIDTH+1 cycles after acceptance.
- Results are valid in the same cycle `done` is high and remain stable afterwards.
- Minimum start-to-start spacing with `go` held high: WIDTH+2 cycles.
- `go` is never sampled in BUSY or DONE, so a simultaneous `go` and `done` does not cause a double start.

## Configuration
- Macro: `SEQ_DIV_ZERO_FAST_EN`.
- Defined:
  - when `go` is accepted with `right`==0, skip BUSY;
  - load quotient = all ones and remainder = `left` at the accepting edge;
  - enter DONE directly, so `done` is high one cycle after acceptance.
- Undefined: a zero divisor runs the full WIDTH steps. The results are bit-identical to the defined case; only the latency differs.

## Structure
- Package `seq_div_pkg`:
  - state enum typedef (IDLE, BUSY, DONE);
  - function for the counter width, `$clog2(WIDTH)` with a minimum of 1.
- Sub-module `seq_div_step`: a purely combinational single restoring step.
  - Inputs: remainder, dividend MSB, divisor.
  - Outputs: next remainder and quotient bit.
  - It is instantiated once; the top level holds all registers and the FSM.

## Test plan
All scenarios use WIDTH=8.
- 100 / 7: `done` exactly 9 cycles after acceptance, quotient 14, remainder 2; `done` high one cycle only.
- 0 / 5 gives quotient 0, remainder 0. 255 / 1 gives quotient 255, remainder 0. 3 / 200 gives quotient 0, remainder 3.
- 37 / 0:
  - quotient 255, remainder 37 in all builds;
  - `done` after 9 cycles without `SEQ_DIV_ZERO_FAST_EN`, after 1 cycle with it.
- `go` held high across two runs (200/9, then `left`/`right` changed to 50/6 after the first `done`):
  - results 22 r 2, then 8 r 2;
  - starts spaced 10 cycles apart;
  - operand changes during BUSY have no effect.
- `reset` pulled low at BUSY step 4 of 100/7:
  - outputs 0 immediately and no `done`;
  - after release, a new 100/7 completes normally.
- `go` dropped one cycle after acceptance: `done` still arrives on schedule with correct results. No further start occurs.

Source files
------------

// File: rtl/seq_div_pkg.sv
// -----------------------------------------------------------------------------
// seq_div_pkg
// Shared definitions for the seq_div_go_done restoring divider.
//   state_t   : controller states (IDLE / BUSY / DONE)
//   cnt_width : width of the step counter, $clog2(width) but never below 1
// -----------------------------------------------------------------------------
package seq_div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// -----------------------------------------------------------------------------
// seq_div_step
// One purely combinational restoring-division step.
// Ports:
//   rem_in   in  WIDTH+1  current partial remainder
//   dvd_msb  in  1        dividend bit shifted into the remainder this step
//   divisor  in  WIDTH    divisor
//   rem_out  out WIDTH+1  next partial remainder (trial kept or restored)
//   q_bit    out 1        quotient bit produced by this step
// -----------------------------------------------------------------------------
module seq_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  // The shifted remainder can reach 2^(WIDTH+1)-1, so the subtraction is
  // done one bit wider than the remainder and the extra MSB acts as the
  // borrow (negative trial) flag.
  logic [WIDTH+1:0] trial;

  always_comb begin
    trial   = {rem_in, dvd_msb} - {2'b00, divisor};
    q_bit   = ~trial[WIDTH+1];
    rem_out = q_bit ? trial[WIDTH:0] : {rem_in[WIDTH-1:0], dvd_msb};
  end

endmodule

// File: rtl/seq_div_go_done.sv
// -----------------------------------------------------------------------------
// seq_div_go_done
// Multi-cycle unsigned restoring divider, responder side of a go/done
// handshake. One quotient bit is produced per cycle.
//
// Handshake: the parent raises go; go is sampled only while the block is
// idle, and the sampling edge captures left/right. done is a registered
// single-cycle pulse, and out_quotient/out_remainder are valid in that
// cycle and stay stable until the next completion. go is ignored while busy
// or presenting done; a go still high on return to idle starts a new run.
//
// Ports:
//   clk            in  1      rising-edge clock
//   reset          in  1      asynchronous active-low reset
//   go             in  1      start request
//   left           in  WIDTH  dividend
//   right          in  WIDTH  divisor
//   out_quotient   out WIDTH  registered quotient
//   out_remainder  out WIDTH  registered remainder
//   done           out 1      registered completion pulse
//   dbg_state      out 2      current controller state (state_t encoding)
//
// Build option: define SEQ_DIV_ZERO_FAST_EN to finish a zero-divisor request
// straight from the accepting edge (done one cycle after acceptance). The
// results are identical to the full-length run.
// -----------------------------------------------------------------------------
module seq_div_go_done
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH:0]   rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] quot_next;
  logic             done_next;
  logic             zero_fast;

  seq_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .dvd_msb (dvd_q[WIDTH-1]),
    .divisor (dsr_q),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // Quotient bits enter at the LSB as dividend bits leave at the MSB, so the
  // dividend register holds the quotient once all steps are done.
  assign quot_next = {dvd_q[WIDTH-2:0], q_bit};

`ifdef SEQ_DIV_ZERO_FAST_EN
  assign zero_fast = (right == '0);
`else
  assign zero_fast = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (go) begin
          state_next = zero_fast ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt == LAST) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic: done is registered, so it is high in the cycle after
  // the DONE state.
  always_comb begin
    done_next = (state == S_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt           <= '0;
      dvd_q         <= '0;
      dsr_q         <= '0;
      rem_q         <= '0;
      out_quotient  <= '0;
      out_remainder <= '0;
      done          <= 1'b0;
    end else begin
      done <= done_next;
      case (state)
        S_IDLE: begin
          if (go) begin
            dvd_q <= left;
            dsr_q <= right;
            rem_q <= '0;
            cnt   <= '0;
            if (zero_fast) begin
              out_quotient  <= '1;
              out_remainder <= left;
            end
          end
        end
        S_BUSY: begin
          dvd_q <= quot_next;
          rem_q <= rem_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            out_quotient  <= quot_next;
            out_remainder <= rem_next[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_seq_div_go_done.sv
// -----------------------------------------------------------------------------
// tb_seq_div_go_done
// Self-checking bench for seq_div_go_done at WIDTH=8: directed cases,
// back-to-back runs with go held, mid-operation reset, and random operands
// checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_seq_div_go_done;
  import seq_div_pkg::*;

  localparam int W = 8;
`ifdef SEQ_DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         go    = 1'b0;
  logic [W-1:0] left  = '0;
  logic [W-1:0] right = '0;
  logic [W-1:0] out_quotient;
  logic [W-1:0] out_remainder;
  logic         done;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  seq_div_go_done #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .go            (go),
    .left          (left),
    .right         (right),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .done          (done),
    .dbg_state     (dbg_state)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string tag, input string what,
                       input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s/%s: observed %0d expected %0d", tag, what, got, exp);
    end
  endtask

  // Reference model: plain arithmetic, divide-by-zero gives all ones / left.
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] l,
                                              input logic [W-1:0] r);
    logic [W-1:0] q, m;
    if (r == '0) begin
      q = '1;
      m = l;
    end else begin
      q = l / r;
      m = l % r;
    end
    return {q, m};
  endfunction

  function automatic int ref_lat(input logic [W-1:0] r);
    return (FAST && r == '0) ? 1 : W + 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for done, counting edges since the last sampling point.
  task automatic wait_done(output int k);
    k = 0;
    while (done !== 1'b1 && k < 30) begin
      step();
      k++;
    end
  endtask

  // One operation; go is kept high for go_cycles edges including acceptance.
  // Operands are scrambled right after capture to show they are not re-read.
  task automatic run_op(input logic [W-1:0] l, input logic [W-1:0] r,
                        input int go_cycles, input string tag);
    int k;
    logic [2*W-1:0] e;
    exp_q.push_back(ref_div(l, r));
    left  = l;
    right = r;
    go    = 1'b1;
    step();                       // acceptance edge
    k = 0;
    while (done !== 1'b1 && k < 30) begin
      if (k >= go_cycles - 1) go = 1'b0;
      if (k == 0) begin
        left  = W'($urandom);
        right = W'($urandom);
      end
      step();
      k++;
    end
    go = 1'b0;
    e = exp_q.pop_front();
    check(tag, "latency", k, ref_lat(r));
    check(tag, "quotient", out_quotient, e[2*W-1:W]);
    check(tag, "remainder", out_remainder, e[W-1:0]);
    step();
    check(tag, "done_one_cycle", done, 0);
    check(tag, "quotient_hold", out_quotient, e[2*W-1:W]);
  endtask

  task automatic idle_no_start(input string tag);
    int pulses;
    pulses = 0;
    repeat (W + 4) begin
      step();
      if (done === 1'b1) pulses++;
    end
    check(tag, "extra_done", pulses, 0);
    check(tag, "state_idle", dbg_state, S_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int pulses;
    logic [W-1:0] l, r;

    // reset state
    #2 reset = 1'b0;
    step();
    step();
    check("reset", "done", done, 0);
    check("reset", "quotient", out_quotient, 0);
    check("reset", "remainder", out_remainder, 0);
    check("reset", "state", dbg_state, S_IDLE);
    reset = 1'b1;
    step();

    // directed cases
    run_op(8'd100, 8'd7,   1, "100/7");
    run_op(8'd0,   8'd5,   1, "0/5");
    run_op(8'd255, 8'd1,   1, "255/1");
    run_op(8'd3,   8'd200, 1, "3/200");
    run_op(8'd37,  8'd0,   1, "37/0");

    // go held high across two runs
    exp_q.push_back(ref_div(8'd200, 8'd9));
    exp_q.push_back(ref_div(8'd50, 8'd6));
    left  = 8'd200;
    right = 8'd9;
    go    = 1'b1;
    step();                       // first acceptance
    left  = 8'd1;                 // changes during BUSY must be ignored
    right = 8'd1;
    wait_done(k);
    check("b2b1", "latency", k, W + 1);
    begin
      logic [2*W-1:0] e;
      e = exp_q.pop_front();
      check("b2b1", "quotient", out_quotient, e[2*W-1:W]);
      check("b2b1", "remainder", out_remainder, e[W-1:0]);
    end
    left  = 8'd50;
    right = 8'd6;
    k = 0;
    while (done !== 1'b1 || k == 0) begin
      if (k >= 30) break;
      if (k == 1) begin
        left  = 8'd255;
        right = 8'd2;
      end
      step();
      k++;
    end
    go = 1'b0;
    check("b2b2", "start_spacing", k, W + 2);
    begin
      logic [2*W-1:0] e;
      e = exp_q.pop_front();
      check("b2b2", "quotient", out_quotient, e[2*W-1:W]);
      check("b2b2", "remainder", out_remainder, e[W-1:0]);
    end
    idle_no_start("b2b_end");

    // reset at BUSY step 4 of 100/7
    left  = 8'd100;
    right = 8'd7;
    go    = 1'b1;
    step();
    go = 1'b0;
    repeat (4) step();
    check("rst_mid", "busy_before", dbg_state, S_BUSY);
    reset = 1'b0;
    #1;
    check("rst_mid", "quotient", out_quotient, 0);
    check("rst_mid", "remainder", out_remainder, 0);
    check("rst_mid", "done", done, 0);
    check("rst_mid", "state", dbg_state, S_IDLE);
    pulses = 0;
    repeat (3) begin
      step();
      if (done === 1'b1) pulses++;
    end
    reset = 1'b1;
    repeat (W + 4) begin
      step();
      if (done === 1'b1) pulses++;
    end
    check("rst_mid", "no_done", pulses, 0);
    run_op(8'd100, 8'd7, 1, "rst_after");

    // go dropped one cycle after acceptance
    run_op(8'd100, 8'd7, 2, "go_drop");
    idle_no_start("go_drop");

    // random operands against the reference model
    for (int i = 0; i < 24; i++) begin
      l = W'($urandom_range(0, 255));
      r = ($urandom_range(0, 5) == 0) ? 8'd0 : W'($urandom_range(1, 255));
      run_op(l, r, $urandom_range(1, 3), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
